// File: rtl/bullet_ctrl.sv
// bullet_ctrl: pool of NUM_BULLETS projectiles spawned from the tank, stepped once per frame.
// Define BULLET_BOUNCE_EN to reflect off walls/edges instead of retiring the bullet.
module bullet_ctrl #(
  parameter int NUM_BULLETS = 4,
  parameter int LIFETIME = 300,
  parameter int COOLDOWN = 15
) (
  input  logic                       frame_clk,
  input  logic                       Reset,
  input  logic                       ShootBullet,
  input  logic [1:0]                 game_end,
  input  logic [9:0]                 TankX,
  input  logic [9:0]                 TankY,
  input  logic [7:0]                 sin,
  input  logic [7:0]                 cos,
  input  logic [9:0]                 EnemyX,
  input  logic [9:0]                 EnemyY,
  input  logic [9:0]                 EnemyS,
  input  logic [NUM_BULLETS-1:0]     isWallX,
  input  logic [NUM_BULLETS-1:0]     isWallY,
  output logic [10*NUM_BULLETS-1:0]  BulletX,
  output logic [10*NUM_BULLETS-1:0]  BulletY,
  output logic [NUM_BULLETS-1:0]     BulletActive,
  output logic                       hit
);
  localparam int N = NUM_BULLETS;
  logic [N-1:0] act, act_n, ov, wx, wy;
  logic [14:0] px [N], py [N], px_n [N], py_n [N];
  logic signed [8:0] vx [N], vy [N], vx_n [N], vy_n [N];
  logic signed [8:0] cv, sv;
  logic [8:0] life [N], life_n [N];
  logic signed [15:0] nx [N], ny [N];
  logic [15:0] cd, cd_n;
  logic shoot_q, req_q, hit_n, taken;

  // screen Y grows downward, so a positive sine moves the bullet up
  assign cv = cos[7] ? -$signed({2'b0, cos[6:0]}) : $signed({2'b0, cos[6:0]});
  assign sv = sin[7] ? $signed({2'b0, sin[6:0]}) : -$signed({2'b0, sin[6:0]});
  assign BulletActive = act;

  for (genvar g = 0; g < N; g++) begin : g_slot
    logic signed [10:0] dx, dy;
    assign nx[g] = $signed({1'b0, px[g]}) + 16'(vx[g]);
    assign ny[g] = $signed({1'b0, py[g]}) + 16'(vy[g]);
    assign dx = $signed({1'b0, px[g][14:5]}) - $signed({1'b0, EnemyX});
    assign dy = $signed({1'b0, py[g][14:5]}) - $signed({1'b0, EnemyY});
    assign ov[g] = act[g] && (dx < 0 ? -dx : dx) <= $signed({1'b0, EnemyS})
                          && (dy < 0 ? -dy : dy) <= $signed({1'b0, EnemyS});
    assign wx[g] = isWallX[g] || nx[g] < 0 || (nx[g] >>> 5) > 16'sd639;
    assign wy[g] = isWallY[g] || ny[g] < 0 || (ny[g] >>> 5) > 16'sd479;
    assign BulletX[10*g +: 10] = px[g][14:5];
    assign BulletY[10*g +: 10] = py[g][14:5];
  end

  always_comb begin
    act_n = act;
    px_n = px;
    py_n = py;
    vx_n = vx;
    vy_n = vy;
    life_n = life;
    cd_n = cd != '0 ? cd - 16'd1 : cd;
    hit_n = |ov;
    taken = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (act[i]) begin
        if (ov[i] || life[i] == '0) act_n[i] = 1'b0;
        else begin
`ifdef BULLET_BOUNCE_EN
          vx_n[i] = wx[i] ? -vx[i] : vx[i];
          vy_n[i] = wy[i] ? -vy[i] : vy[i];
          px_n[i] = wx[i] ? px[i] : nx[i][14:0];
          py_n[i] = wy[i] ? py[i] : ny[i][14:0];
`else
          act_n[i] = !(wx[i] || wy[i]);
          px_n[i] = nx[i][14:0];
          py_n[i] = ny[i][14:0];
`endif
          life_n[i] = life[i] - 9'd1;
        end
      end else if (req_q && cd == '0 && !taken) begin
        taken = 1'b1;
        act_n[i] = 1'b1;
        px_n[i] = {TankX, 5'b0};
        py_n[i] = {TankY, 5'b0};
        vx_n[i] = cv;
        vy_n[i] = sv;
        life_n[i] = 9'(LIFETIME);
        cd_n = 16'(COOLDOWN);
      end
    end
  end

  // req_q registers the rising edge so the spawn lands one frame after shoot_q sees it
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      act <= '0;
      px <= '{default: '0};
      py <= '{default: '0};
      vx <= '{default: '0};
      vy <= '{default: '0};
      life <= '{default: '0};
      cd <= '0;
      shoot_q <= 1'b0;
      req_q <= 1'b0;
      hit <= 1'b0;
    end else if (game_end != 2'b00) begin
      act <= '0;
      px <= '{default: '0};
      py <= '{default: '0};
      cd <= '0;
      shoot_q <= ShootBullet;
      req_q <= 1'b0;
      hit <= 1'b0;
    end else begin
      act <= act_n;
      px <= px_n;
      py <= py_n;
      vx <= vx_n;
      vy <= vy_n;
      life <= life_n;
      cd <= cd_n;
      shoot_q <= ShootBullet;
      req_q <= ShootBullet & ~shoot_q;
      hit <= hit_n;
    end
  end
endmodule
